muxn_scan: RTL and testbench

Parametrised, registered N-channel selector for the single-cycle CPU lab board: picks one WIDTH-bit channel from a packed input bus, either by debounced switch select or by an automatic scan of all channels. Sits between datapath/debug signals and the board LEDs/display, replacing ad-hoc 2-way switch muxes. The output is registered and glitch-free, and it reports which channel is currently shown.

---
 rtl/muxn_pkg.sv | 23 ++
 rtl/muxn_scan_if.sv | 39 +++
 rtl/muxn_scan_sel_debounce.sv | 48 ++++
 rtl/muxn_scan.sv | 111 +++++++++++
 tb/tb_muxn_scan.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - shared defaults, mode type and clog2 helper for muxn_scan
package muxn_pkg;

    localparam int DEF_WIDTH       = 3;
    localparam int DEF_N           = 4;
    localparam int DEF_DEBOUNCE    = 4;
    localparam int DEF_SCAN_PERIOD = 16;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/muxn_scan_if.sv
// rtl/muxn_scan_if.sv - channel bus, select inputs and status outputs of muxn_scan
interface muxn_scan_if
    import muxn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
);

    localparam int SELW = clog2(N);

    logic [N*WIDTH-1:0] in_bus;
    logic [SELW-1:0]    sel;
    logic               scan_en;
    logic [WIDTH-1:0]   out;
    logic [SELW-1:0]    out_ch;
    logic               sel_changed;
    logic               sel_invalid;

    modport master (
        output in_bus,
        output sel,
        output scan_en,
        input  out,
        input  out_ch,
        input  sel_changed,
        input  sel_invalid
    );

    modport slave (
        input  in_bus,
        input  sel,
        input  scan_en,
        output out,
        output out_ch,
        output sel_changed,
        output sel_invalid
    );

endinterface

// File: rtl/muxn_scan_sel_debounce.sv
// rtl/muxn_scan_sel_debounce.sv - 2-flop synchroniser plus saturating debounce counter
module sel_debounce
    import muxn_pkg::*;
#(
    parameter int W        = 2,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         stable
);

    localparam int          CW      = (DEBOUNCE > 1) ? clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  cand;
    logic [W-1:0]  held;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            held  <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            held <= dout;
        end
    end

    // The last accepted value is held while a new candidate is still settling.
    assign stable = (cnt == CNT_MAX);
    assign dout   = stable ? cand : held;

endmodule

// File: rtl/muxn_scan.sv
// rtl/muxn_scan.sv - registered N-channel selector with debounced select; MUXN_SCAN_EN adds auto-scan
module muxn_scan
    import muxn_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int N           = DEF_N,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int SCAN_PERIOD = DEF_SCAN_PERIOD
) (
    input  logic         clk,
    input  logic         rst,
    muxn_scan_if.slave   bus
);

    localparam int              SELW    = clog2(N);
    localparam logic [SELW:0]   N_EXT   = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [SELW-1:0]  deb_sel;
    logic             unused_deb_stable;
    logic             deb_valid;
    logic [SELW-1:0]  active;
    logic [SELW-1:0]  active_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             invalid_nxt;
    logic             scan_step;
    mode_e            mode;

    sel_debounce #(
        .W        (SELW),
        .DEBOUNCE (DEBOUNCE)
    ) u_sel_debounce (
        .clk    (clk),
        .rst    (rst),
        .din    (bus.sel),
        .dout   (deb_sel),
        .stable (unused_deb_stable)
    );

    assign deb_valid = ({1'b0, deb_sel} < N_EXT);

`ifdef MUXN_SCAN_EN
    localparam int              CNTW      = clog2(SCAN_PERIOD);
    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_PERIOD - 1);

    logic [CNTW-1:0] scan_cnt;

    assign mode      = bus.scan_en ? MODE_SCAN : MODE_MANUAL;
    assign scan_step = (mode == MODE_SCAN) && (scan_cnt == SCAN_LAST);

    // Held at zero in manual mode so every scan entry starts a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (mode == MODE_MANUAL || scan_step) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end
`else
    localparam int unused_scan_period = SCAN_PERIOD;
    logic          unused_scan_en;

    assign unused_scan_en = bus.scan_en;
    assign mode           = MODE_MANUAL;
    assign scan_step      = 1'b0;
`endif

    always_comb begin
        active_nxt  = active;
        invalid_nxt = 1'b0;
        if (mode == MODE_SCAN) begin
            if (scan_step) begin
                active_nxt = (active == LAST_CH) ? '0 : active + 1'b1;
            end
        end else begin
            invalid_nxt = !deb_valid;
            if (deb_valid && (deb_sel != active)) begin
                active_nxt = deb_sel;
            end
        end
    end

    // The output slice follows the next channel so out and out_ch change on the same edge.
    always_comb begin
        out_nxt = '0;
        for (int k = 0; k < N; k++) begin
            if (active_nxt == SELW'(k)) begin
                out_nxt = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active          <= '0;
            bus.out         <= '0;
            bus.out_ch      <= '0;
            bus.sel_changed <= 1'b0;
            bus.sel_invalid <= 1'b0;
        end else begin
            active          <= active_nxt;
            bus.out         <= out_nxt;
            bus.out_ch      <= active_nxt;
            bus.sel_changed <= (active_nxt != active);
            bus.sel_invalid <= invalid_nxt;
        end
    end

endmodule

// File: tb/tb_muxn_scan.sv
// tb/tb_muxn_scan.sv - directed checks of muxn_scan; scan checks built when MUXN_SCAN_EN is defined
module tb_muxn_scan;
    import muxn_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    muxn_scan_if #(.WIDTH(3), .N(4)) b4 ();
    muxn_scan_if #(.WIDTH(3), .N(3)) b3 ();

    muxn_scan #(.WIDTH(3), .N(4), .DEBOUNCE(4), .SCAN_PERIOD(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    muxn_scan #(.WIDTH(3), .N(3), .DEBOUNCE(4), .SCAN_PERIOD(16)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    int errors = 0;
    int checks = 0;
    int chg_cnt;
    int seen1;

    logic [2:0] c4 [4];
    logic [2:0] c3 [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bus();
        b4.in_bus = {c4[3], c4[2], c4[1], c4[0]};
        b3.in_bus = {c3[2], c3[1], c3[0]};
    endtask

    initial begin
        c4 = '{3'd5, 3'd2, 3'd7, 3'd1};
        c3 = '{3'd4, 3'd3, 3'd6};
        rst        = 1'b1;
        b4.sel     = 2'd0;
        b3.sel     = 2'd0;
        b4.scan_en = 1'b0;
        b3.scan_en = 1'b0;
        drive_bus();
        step(2);

        check("rst_out",     32'(b4.out), 32'd0);
        check("rst_out_ch",  32'(b4.out_ch), 32'd0);
        check("rst_chg",     32'(b4.sel_changed), 32'd0);
        check("rst_inv",     32'(b4.sel_invalid), 32'd0);

        rst = 1'b0;
        step(1);
        check("first_out4", 32'(b4.out), 32'd5);
        check("first_out3", 32'(b3.out), 32'd4);

        c4[0] = 3'd6;
        drive_bus();
        step(1);
        check("datapath", 32'(b4.out), 32'd6);

        b4.sel = 2'd2;
        step(6);
        check("sel_pre_ch",  32'(b4.out_ch), 32'd0);
        check("sel_pre_chg", 32'(b4.sel_changed), 32'd0);
        step(1);
        check("sel_ch",  32'(b4.out_ch), 32'd2);
        check("sel_out", 32'(b4.out), 32'd7);
        check("sel_chg", 32'(b4.sel_changed), 32'd1);
        step(1);
        check("sel_chg_once", 32'(b4.sel_changed), 32'd0);
        check("sel_hold_ch",  32'(b4.out_ch), 32'd2);

        b4.sel = 2'd3;
        step(3);
        b4.sel  = 2'd2;
        chg_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chg_cnt += int'(b4.sel_changed);
        end
        check("glitch_chg", 32'(chg_cnt), 32'd0);
        check("glitch_ch",  32'(b4.out_ch), 32'd2);

        b4.sel = 2'd1;
        step(4);
        b4.sel  = 2'd2;
        chg_cnt = 0;
        seen1   = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            chg_cnt += int'(b4.sel_changed);
            if (b4.out_ch == 2'd1) seen1++;
        end
        check("pulse4_seen", 32'(seen1), 32'd4);
        check("pulse4_chg",  32'(chg_cnt), 32'd2);
        check("pulse4_ch",   32'(b4.out_ch), 32'd2);

        b3.sel = 2'd3;
        step(6);
        check("inv_pre",    32'(b3.sel_invalid), 32'd0);
        step(1);
        check("inv_set",    32'(b3.sel_invalid), 32'd1);
        check("inv_hold",   32'(b3.out_ch), 32'd0);
        check("inv_out",    32'(b3.out), 32'd4);
        b3.sel = 2'd1;
        step(6);
        check("inv_stay",   32'(b3.sel_invalid), 32'd1);
        step(1);
        check("inv_clear",  32'(b3.sel_invalid), 32'd0);
        check("inv_new_ch", 32'(b3.out_ch), 32'd1);
        check("inv_new_out", 32'(b3.out), 32'd3);
        check("inv_new_chg", 32'(b3.sel_changed), 32'd1);

`ifdef MUXN_SCAN_EN
        b4.sel = 2'd0;
        step(8);
        check("prescan_ch", 32'(b4.out_ch), 32'd0);
        b4.scan_en = 1'b1;
        b4.sel     = 2'd2;
        for (int k = 1; k <= 4; k++) begin
            step(15);
            check("scan_hold", 32'(b4.out_ch), 32'((k - 1) % 4));
            step(1);
            check("scan_step", 32'(b4.out_ch), 32'(k % 4));
            check("scan_chg",  32'(b4.sel_changed), 32'd1);
            check("scan_out",  32'(b4.out), 32'(c4[k % 4]));
            check("scan_inv",  32'(b4.sel_invalid), 32'd0);
        end
        b4.scan_en = 1'b0;
        step(1);
        check("scan_exit", 32'(b4.out_ch), 32'd2);

        b4.scan_en = 1'b1;
        step(8);
        check("midscan_ch", 32'(b4.out_ch), 32'd2);
        rst = 1'b1;
        #2;
        check("midscan_rst_ch",  32'(b4.out_ch), 32'd0);
        check("midscan_rst_out", 32'(b4.out), 32'd0);
        check("midscan_rst_chg", 32'(b4.sel_changed), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(15);
        check("rescan_hold", 32'(b4.out_ch), 32'd0);
        step(1);
        check("rescan_step", 32'(b4.out_ch), 32'd1);
        b4.scan_en = 1'b0;
        step(1);
        check("rescan_exit", 32'(b4.out_ch), 32'd2);
`else
        b4.scan_en = 1'b1;
        chg_cnt    = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            chg_cnt += int'(b4.sel_changed);
        end
        check("noscan_chg", 32'(chg_cnt), 32'd0);
        check("noscan_ch",  32'(b4.out_ch), 32'd2);
        b4.scan_en = 1'b0;
`endif

        b4.sel = 2'd1;
        step(4);
        rst = 1'b1;
        #2;
        check("middeb_rst_ch",  32'(b4.out_ch), 32'd0);
        check("middeb_rst_out", 32'(b4.out), 32'd0);
        check("middeb_rst_ch3", 32'(b3.out_ch), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(6);
        check("middeb_pre", 32'(b4.out_ch), 32'd0);
        step(1);
        check("middeb_ch",  32'(b4.out_ch), 32'd1);
        check("middeb_out", 32'(b4.out), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
